cond_resolver: RTL

//  Consumer side of the ALU flag register. Evaluates ARMv8 B.cond condition codes against the
//  4-bit flag vector. Tracks in-flight flag-setting ops and stalls a branch until its flags are final.

---
 rtl/cond_resolver_if.sv | 25 ++
 rtl/cond_resolver.sv | 95 +++++++++
 2 files changed

// File: rtl/cond_resolver_if.sv
// cond_resolver_if: decode/flag-register side signals of the branch condition resolver.
interface cond_resolver_if #(parameter int PEND_W = 2);
    logic              flag_issue;
    logic              flag_wr;
    logic [3:0]        alu_flags;
    logic [3:0]        Flags;
    logic              req_valid;
    logic [3:0]        req_cond;
    logic              req_ready;
    logic              stall;
    logic              res_valid;
    logic              res_taken;
    logic [PEND_W-1:0] pend_cnt;
    logic              err_proto;

    modport master (
        output flag_issue, flag_wr, alu_flags, Flags, req_valid, req_cond,
        input  req_ready, stall, res_valid, res_taken, pend_cnt, err_proto
    );

    modport slave (
        input  flag_issue, flag_wr, alu_flags, Flags, req_valid, req_cond,
        output req_ready, stall, res_valid, res_taken, pend_cnt, err_proto
    );
endinterface

// File: rtl/cond_resolver.sv
// cond_resolver: evaluates ARMv8 B.cond codes on forwarded flags, stalling a branch
// until every older in-flight flag-setting op has written back.
module cond_resolver #(
    parameter int MAX_PEND = 3,
    parameter int PEND_W   = 2
) (
    input logic            clk,
    input logic            reset,
    cond_resolver_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [3:0]        heldCond;
    logic [3:0]        effFlags;
    logic [PEND_W-1:0] nextCnt;
    logic              decr;
    logic              overflow;

    // Flag order is [0]N [1]Z [2]V [3]C.
    function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n = f[0];
        z = f[1];
        v = f[2];
        cy = f[3];
        condHolds = 1'b1;
        case (c)
            4'h0: condHolds = z;
            4'h1: condHolds = !z;
            4'h2: condHolds = cy;
            4'h3: condHolds = !cy;
            4'h4: condHolds = n;
            4'h5: condHolds = !n;
            4'h6: condHolds = v;
            4'h7: condHolds = !v;
            4'h8: condHolds = cy && !z;
            4'h9: condHolds = !(cy && !z);
            4'hA: condHolds = n == v;
            4'hB: condHolds = n != v;
            4'hC: condHolds = !z && (n == v);
            4'hD: condHolds = !(!z && (n == v));
            default: condHolds = 1'b1;
        endcase
    endfunction

    // A write with nothing tracked is legal and must not underflow the count.
    always_comb begin
        effFlags = bus.flag_wr ? bus.alu_flags : bus.Flags;
        decr     = bus.flag_wr && (bus.pend_cnt != '0);
        overflow = bus.flag_issue && !bus.flag_wr && (bus.pend_cnt == PEND_W'(MAX_PEND));
        nextCnt  = overflow ? bus.pend_cnt
                            : bus.pend_cnt + PEND_W'(bus.flag_issue) - PEND_W'(decr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            heldCond      <= '0;
            bus.req_ready <= 1'b1;
            bus.stall     <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_taken <= 1'b0;
            bus.pend_cnt  <= '0;
            bus.err_proto <= 1'b0;
        end else begin
            bus.pend_cnt  <= nextCnt;
            bus.res_valid <= 1'b0;
            if (overflow || (state == WAIT && bus.flag_issue))
                bus.err_proto <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.req_valid && nextCnt == '0) begin
                        bus.res_valid <= 1'b1;
                        bus.res_taken <= condHolds(bus.req_cond, effFlags);
                    end else if (bus.req_valid) begin
                        heldCond      <= bus.req_cond;
                        state         <= WAIT;
                        bus.req_ready <= 1'b0;
                        bus.stall     <= 1'b1;
                    end
                end
                default: begin
                    if (nextCnt == '0) begin
                        bus.res_valid <= 1'b1;
                        bus.res_taken <= condHolds(heldCond, effFlags);
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                        bus.stall     <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
